// File: rtl/dbg_entry_ctrl.sv
// rtl/dbg_entry_ctrl.sv - debug-mode entry/exit controller: halt cause capture, pipeline drain, resume handshake
module dbg_entry_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  breakpoint,
  input  logic                  ebreak_ex,
  input  logic                  dcsr_ebreakm,
  input  logic                  dcsr_step,
  input  logic                  haltreq,
  input  logic                  resumereq,
  input  logic                  instr_retire,
  input  logic                  pipe_idle,
  input  logic [ADDR_WIDTH-1:0] pc_ex,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  dpc_wr_en,
  input  logic [DATA_WIDTH-1:0] dpc_wr_data,
  output logic                  dbg_mode,
  output logic                  halted,
  output logic                  pipe_flush,
  output logic                  pipe_stall,
  output logic [ADDR_WIDTH-1:0] dpc,
  output logic [2:0]            dcsr_cause,
  output logic                  resume_valid,
  output logic [ADDR_WIDTH-1:0] resume_pc,
  output logic                  resumeack
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, RESUME} state_t;

  state_t                state, state_next;
  logic                  step_armed, step_armed_next;
  logic [ADDR_WIDTH-1:0] dpc_next;
  logic [2:0]            cause_next;
  logic                  entry;
  logic                  in_debug_next;

  always_comb begin
    state_next      = state;
    step_armed_next = step_armed;
    dpc_next        = dpc;
    cause_next      = dcsr_cause;
    entry           = 1'b0;
    case (state)
      RUN: begin
        // trigger/ebreak did not execute, so dpc points at them; haltreq/step resume at the next pc
        if (breakpoint && !dbg_mode) begin
          entry      = 1'b1;
          cause_next = 3'd2;
          dpc_next   = pc_ex;
        end else if (ebreak_ex && dcsr_ebreakm && !dbg_mode) begin
          entry      = 1'b1;
          cause_next = 3'd1;
          dpc_next   = pc_ex;
        end else if (haltreq) begin
          entry      = 1'b1;
          cause_next = 3'd3;
          dpc_next   = pc_next;
        end else if (step_armed && instr_retire) begin
          entry      = 1'b1;
          cause_next = 3'd4;
          dpc_next   = pc_next;
        end
        if (entry) begin
          state_next      = DRAIN;
          step_armed_next = 1'b0;
        end
      end
      DRAIN: begin
        if (pipe_idle) state_next = HALTED;
      end
      HALTED: begin
        if (dpc_wr_en) dpc_next = dpc_wr_data[ADDR_WIDTH-1:0];
        if (resumereq && !haltreq) state_next = RESUME;
      end
      RESUME: begin
        state_next      = RUN;
        step_armed_next = dcsr_step;
      end
      default: state_next = RUN;
    endcase
  end

  assign in_debug_next = (state_next == HALTED) || (state_next == RESUME);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state        <= RUN;
      step_armed   <= 1'b0;
      dpc          <= '0;
      dcsr_cause   <= 3'd0;
      dbg_mode     <= 1'b0;
      halted       <= 1'b0;
      pipe_flush   <= 1'b0;
      pipe_stall   <= 1'b0;
      resume_valid <= 1'b0;
      resumeack    <= 1'b0;
    end else begin
      state        <= state_next;
      step_armed   <= step_armed_next;
      dpc          <= dpc_next;
      dcsr_cause   <= cause_next;
      dbg_mode     <= in_debug_next;
      halted       <= in_debug_next;
      pipe_flush   <= entry;
      pipe_stall   <= (state_next != RUN);
      resume_valid <= (state_next == RESUME);
      resumeack    <= (state_next == RESUME);
    end
  end

  assign resume_pc = dpc;

endmodule

// File: tb/tb_dbg_entry_ctrl.sv
// tb/tb_dbg_entry_ctrl.sv - bench for dbg_entry_ctrl: directed halt/resume scenarios, then random traffic
module tb_dbg_entry_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  bit          clk;
  logic        cpu_rst;
  logic        breakpoint, ebreak_ex, dcsr_ebreakm, dcsr_step;
  logic        haltreq, resumereq, instr_retire, pipe_idle;
  logic [AW-1:0] pc_ex, pc_next;
  logic        dpc_wr_en;
  logic [DW-1:0] dpc_wr_data;
  logic        dbg_mode, halted, pipe_flush, pipe_stall, resume_valid, resumeack;
  logic [AW-1:0] dpc, resume_pc;
  logic [2:0]  dcsr_cause;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dbg_entry_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .cpu_clk(clk), .cpu_rst(cpu_rst), .breakpoint(breakpoint), .ebreak_ex(ebreak_ex),
    .dcsr_ebreakm(dcsr_ebreakm), .dcsr_step(dcsr_step), .haltreq(haltreq), .resumereq(resumereq),
    .instr_retire(instr_retire), .pipe_idle(pipe_idle), .pc_ex(pc_ex), .pc_next(pc_next),
    .dpc_wr_en(dpc_wr_en), .dpc_wr_data(dpc_wr_data), .dbg_mode(dbg_mode), .halted(halted),
    .pipe_flush(pipe_flush), .pipe_stall(pipe_stall), .dpc(dpc), .dcsr_cause(dcsr_cause),
    .resume_valid(resume_valid), .resume_pc(resume_pc), .resumeack(resumeack)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the core is either running, draining, halted, or in its resume cycle
  logic          m_started = 1'b0;
  logic          m_drain, m_halt, m_resume, m_armed, m_flush;
  logic [AW-1:0] m_dpc;
  logic [2:0]    m_cause;
  logic          ev_trig, ev_eb, ev_hr, ev_st;

  assign ev_trig = breakpoint;
  assign ev_eb   = ebreak_ex & dcsr_ebreakm;
  assign ev_hr   = haltreq;
  assign ev_st   = m_armed & instr_retire;

  always @(posedge clk) begin
    m_started <= 1'b1;
    m_flush   <= 1'b0;
    if (cpu_rst) begin
      m_drain <= 1'b0; m_halt <= 1'b0; m_resume <= 1'b0; m_armed <= 1'b0;
      m_dpc <= '0; m_cause <= 3'd0;
    end else if (m_resume) begin
      m_resume <= 1'b0; m_halt <= 1'b0; m_armed <= dcsr_step;
    end else if (m_halt) begin
      if (dpc_wr_en) m_dpc <= dpc_wr_data[AW-1:0];
      if (resumereq && !haltreq) m_resume <= 1'b1;
    end else if (m_drain) begin
      if (pipe_idle) begin m_drain <= 1'b0; m_halt <= 1'b1; end
    end else if (ev_trig | ev_eb | ev_hr | ev_st) begin
      m_drain <= 1'b1; m_flush <= 1'b1; m_armed <= 1'b0;
      m_cause <= ev_trig ? 3'd2 : ev_eb ? 3'd1 : ev_hr ? 3'd3 : 3'd4;
      m_dpc   <= (ev_trig | ev_eb) ? pc_ex : pc_next;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("m_dbg_mode", dbg_mode, m_halt);
      chk("m_halted", halted, m_halt);
      chk("m_pipe_flush", pipe_flush, m_flush);
      chk("m_pipe_stall", pipe_stall, m_drain | m_halt);
      chk("m_dpc", dpc, m_dpc);
      chk("m_cause", dcsr_cause, m_cause);
      chk("m_resume_valid", resume_valid, m_resume);
      chk("m_resumeack", resumeack, m_resume);
      chk("m_resume_pc", resume_pc, m_dpc);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    breakpoint = 0; ebreak_ex = 0; dcsr_ebreakm = 0; dcsr_step = 0; haltreq = 0;
    resumereq = 0; instr_retire = 0; pipe_idle = 1; pc_ex = '0; pc_next = '0;
    dpc_wr_en = 0; dpc_wr_data = '0;
  endtask

  task automatic do_resume(input logic [AW-1:0] exp_pc, input logic step);
    resumereq = 1; dcsr_step = step;
    tick();
    chk("res_valid", resume_valid, 1); chk("res_ack", resumeack, 1);
    chk("res_dbg_mode", dbg_mode, 1); chk("res_pc", resume_pc, exp_pc);
    tick();
    chk("run_dbg_mode", dbg_mode, 0); chk("run_stall", pipe_stall, 0);
    chk("run_valid", resume_valid, 0);
    tick();
    chk("no_reresume", resumeack, 0);
    resumereq = 0;
  endtask

  initial begin
    cpu_rst = 1; idle_inputs();
    tick(3);
    chk("rst_halted", halted, 0); chk("rst_dbg_mode", dbg_mode, 0);
    chk("rst_dpc", dpc, 0); chk("rst_cause", dcsr_cause, 0);
    cpu_rst = 0;
    tick();

    // breakpoint entry latency
    breakpoint = 1; pc_ex = 32'h100;
    tick(); breakpoint = 0;
    chk("t1_flush", pipe_flush, 1); chk("t1_stall", pipe_stall, 1); chk("t1_not_halted", halted, 0);
    tick();
    chk("t1_halted", halted, 1); chk("t1_flush_off", pipe_flush, 0);
    chk("t1_dpc", dpc, 32'h100); chk("t1_cause", dcsr_cause, 2);
    do_resume(32'h100, 0);

    // trigger beats haltreq; haltreq alone; haltreq blocks resume
    haltreq = 1; breakpoint = 1; pc_ex = 32'h200; pc_next = 32'h204;
    tick(); haltreq = 0; breakpoint = 0;
    tick();
    chk("t2_cause", dcsr_cause, 2); chk("t2_dpc", dpc, 32'h200);
    haltreq = 1; resumereq = 1;
    tick(2);
    chk("t2_hold_valid", resume_valid, 0); chk("t2_hold_halted", halted, 1);
    haltreq = 0; resumereq = 0;
    do_resume(32'h200, 0);
    haltreq = 1; pc_next = 32'h304;
    tick(); haltreq = 0;
    tick();
    chk("t2_hr_cause", dcsr_cause, 3); chk("t2_hr_dpc", dpc, 32'h304);
    do_resume(32'h304, 0);

    // ebreak gated by ebreakm
    ebreak_ex = 1; dcsr_ebreakm = 0; pc_ex = 32'h40;
    tick();
    chk("t3_no_flush", pipe_flush, 0);
    dcsr_ebreakm = 1;
    tick(); ebreak_ex = 0; dcsr_ebreakm = 0;
    chk("t3_flush", pipe_flush, 1);
    tick();
    chk("t3_halted", halted, 1); chk("t3_cause", dcsr_cause, 1); chk("t3_dpc", dpc, 32'h40);

    // debugger dpc write then stepped resume
    dpc_wr_en = 1; dpc_wr_data = 32'h8000;
    tick(); dpc_wr_en = 0;
    chk("t4_dpc_wr", dpc, 32'h8000);
    do_resume(32'h8000, 1);
    instr_retire = 1; pc_next = 32'h8004;
    tick(); instr_retire = 0;
    chk("t5_flush", pipe_flush, 1);
    tick();
    chk("t5_halted", halted, 1); chk("t5_cause", dcsr_cause, 4); chk("t5_dpc", dpc, 32'h8004);
    do_resume(32'h8004, 0);
    dpc_wr_en = 1; dpc_wr_data = 32'hDEAD;
    tick(); dpc_wr_en = 0;
    chk("t5_wr_ignored", dpc, 32'h8004);

    // long drain with masked triggers, then reset mid-drain
    pipe_idle = 0; haltreq = 1; pc_next = 32'h500;
    tick(); haltreq = 0;
    for (int i = 0; i < 5; i++) begin
      breakpoint = (i % 2 == 0); pc_ex = 32'h600;
      tick();
      chk("t6_stall", pipe_stall, 1); chk("t6_not_halted", halted, 0);
      chk("t6_cause", dcsr_cause, 3); chk("t6_dpc", dpc, 32'h500);
    end
    breakpoint = 0; cpu_rst = 1;
    tick();
    chk("t6_rst_stall", pipe_stall, 0); chk("t6_rst_cause", dcsr_cause, 0);
    chk("t6_rst_dpc", dpc, 0); chk("t6_rst_flush", pipe_flush, 0);
    cpu_rst = 0; pipe_idle = 1;
    tick();

    for (int i = 0; i < 3000; i++) begin
      cpu_rst      = ($urandom_range(0, 199) == 0);
      breakpoint   = ($urandom_range(0, 19) == 0);
      ebreak_ex    = ($urandom_range(0, 9) == 0);
      dcsr_ebreakm = $urandom_range(0, 1);
      dcsr_step    = ($urandom_range(0, 2) == 0);
      haltreq      = ($urandom_range(0, 24) == 0);
      resumereq    = ($urandom_range(0, 3) == 0);
      instr_retire = $urandom_range(0, 1);
      pipe_idle    = ($urandom_range(0, 4) < 3);
      pc_ex        = $urandom & 32'hFFFF_FFFC;
      pc_next      = $urandom & 32'hFFFF_FFFC;
      dpc_wr_en    = ($urandom_range(0, 4) == 0);
      dpc_wr_data  = $urandom;
      tick();
    end
    idle_inputs(); cpu_rst = 0;
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
